// File: rtl/cordic_sqrt_pkg.sv
// Shared constants, shift schedule and FSM encoding for the folded hyperbolic CORDIC square-root unit.
package cordic_sqrt_pkg;

    localparam int SYM_WIDTH_DEF = 1;
    localparam int INT_WIDTH_DEF = 1;
    localparam int DEC_WIDTH_DEF = 14;
    localparam int ITERS_DEF     = 14;
    localparam int INV_KH_Q14    = 19784;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        COMP,
        DONE
    } state_t;

    function automatic int calc_width(input int sym_w, input int int_w, input int dec_w);
        return sym_w + int_w + dec_w;
    endfunction

    // Shifts 4 and 13 are repeated so the hyperbolic iteration converges.
    function automatic int num_passes(input int iters);
        return iters + ((iters >= 4) ? 1 : 0) + ((iters >= 13) ? 1 : 0);
    endfunction

    function automatic int sched(input int idx, input int iters);
        int pos;
        int res;
        pos = 0;
        res = 1;
        for (int k = 1; k <= iters; k++) begin
            if (pos == idx) res = k;
            pos++;
            if (k == 4 || k == 13) begin
                if (pos == idx) res = k;
                pos++;
            end
        end
        return res;
    endfunction

    function automatic int a_min(input int dec_w);
        return 1 << (dec_w - 6);
    endfunction

    function automatic int a_max(input int dec_w);
        return 7 << (dec_w - 2);
    endfunction

    function automatic int inv_kh(input int dec_w);
        return (dec_w >= 14) ? (INV_KH_Q14 << (dec_w - 14)) : (INV_KH_Q14 >> (14 - dec_w));
    endfunction

    localparam int W_DEF = calc_width(SYM_WIDTH_DEF, INT_WIDTH_DEF, DEC_WIDTH_DEF);
    localparam int P_DEF = num_passes(ITERS_DEF);

endpackage

// File: rtl/cordic_sqrt_seq_step.sv
// One hyperbolic-vectoring shift-add stage with a runtime shift amount; purely combinational.
module cordic_hyp_step #(
    parameter int W  = 16,
    parameter int SW = 4
) (
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic        [SW-1:0] shift,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic                d_neg;

    always_comb begin
        x_sh  = x_in >>> shift;
        y_sh  = y_in >>> shift;
        // Matching signs mean y is still pulling away from zero in the x direction.
        d_neg = (x_in[W-1] == y_in[W-1]);
        x_out = d_neg ? (x_in - y_sh) : (x_in + y_sh);
        y_out = d_neg ? (y_in - x_sh) : (y_in + x_sh);
    end

endmodule

// File: rtl/cordic_sqrt_seq.sv
// Folded CORDIC square root: one shift-add stage reused over P passes under a small FSM.
// Define CORDIC_SQRT_GAIN_COMP_EN to add a COMP state that removes the hyperbolic gain.
module cordic_sqrt_seq
    import cordic_sqrt_pkg::*;
#(
    parameter int SYM_WIDTH = SYM_WIDTH_DEF,
    parameter int INT_WIDTH = INT_WIDTH_DEF,
    parameter int DEC_WIDTH = DEC_WIDTH_DEF,
    parameter int ITERS     = ITERS_DEF,
    localparam int W        = calc_width(SYM_WIDTH, INT_WIDTH, DEC_WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         busy
);

    localparam int P  = num_passes(ITERS);
    localparam int CW = $clog2(P + 1);
    localparam int SW = $clog2(ITERS + 1);
    localparam logic signed [W-1:0] A_MIN   = W'(a_min(DEC_WIDTH));
    localparam logic signed [W-1:0] A_MAX   = W'(a_max(DEC_WIDTH));
    localparam logic signed [W-1:0] QUARTER = W'(1 << (DEC_WIDTH - 2));
    localparam logic [CW-1:0]       LAST    = CW'(P - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0]        out_data_q, out_data_d;
    logic                out_err_q, out_err_d;

    logic signed [W-1:0] a_s;
    logic signed [W-1:0] x_step, y_step;
    logic [SW-1:0]       shift;
    logic                in_range;

    assign a_s      = in_data;
    assign in_range = (a_s >= A_MIN) && (a_s <= A_MAX);
    assign shift    = SW'(sched(int'(cnt_q), ITERS));

    cordic_hyp_step #(
        .W  (W),
        .SW (SW)
    ) u_step (
        .x_in  (x_q),
        .y_in  (y_q),
        .shift (shift),
        .x_out (x_step),
        .y_out (y_step)
    );

`ifdef CORDIC_SQRT_GAIN_COMP_EN
    localparam logic signed [W-1:0]   INV_KH  = W'(inv_kh(DEC_WIDTH));
    localparam logic signed [2*W-1:0] MAX_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_sh;
    logic [W-1:0]          comp_val;

    always_comb begin
        prod     = x_q * INV_KH;
        prod_sh  = prod >>> DEC_WIDTH;
        comp_val = (prod_sh > MAX_POS) ? MAX_POS[W-1:0] : prod_sh[W-1:0];
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_range) begin
                        // x^2 - y^2 = a, so the vectoring magnitude is sqrt(a).
                        x_d     = a_s + QUARTER;
                        y_d     = a_s - QUARTER;
                        cnt_d   = '0;
                        state_d = ITER;
                    end else begin
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                        state_d    = DONE;
                    end
                end
            end
            ITER: begin
                x_d   = x_step;
                y_d   = y_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
`ifdef CORDIC_SQRT_GAIN_COMP_EN
                    state_d = COMP;
`else
                    out_data_d = x_step;
                    state_d    = DONE;
`endif
                end
            end
`ifdef CORDIC_SQRT_GAIN_COMP_EN
            COMP: begin
                out_data_d = comp_val;
                state_d    = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    out_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_cordic_sqrt_seq.sv
// Directed and random-legal checks of the folded CORDIC square root against a real-valued model.
module tb_cordic_sqrt_seq;

`ifdef CORDIC_SQRT_GAIN_COMP_EN
    localparam int  LAT  = 17;
    localparam bit  GAIN = 1'b1;
    localparam int  E_1  = 16'h4000;
    localparam int  E_Q  = 16'h2000;
    localparam int  E_16 = 16'h1000;
`else
    localparam int  LAT  = 16;
    localparam bit  GAIN = 1'b0;
    localparam int  E_1  = 16'h3500;
    localparam int  E_Q  = 16'h1A80;
    localparam int  E_16 = 16'h0D40;
`endif
    localparam int TOL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_err;
    logic        busy;

    int  n_cmp = 0;
    int  n_bad = 0;
    real k_h;

    always #5 clk = ~clk;

    cordic_sqrt_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        n_cmp++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int model(input int a);
        real r;
        r = $sqrt(real'(a) * 16384.0);
        if (!GAIN) r = r * k_h;
        return $rtoi(r + 0.5);
    endfunction

    // Presents a, waits for acceptance, counts edges to out_valid, then completes the handshake.
    task automatic run_op(input string tag, input int a, output int lat, output int data, output int err);
        int g;
        in_data  = 16'(a);
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 40) begin
            tick();
            g++;
        end
        chk({tag, "_accept"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        data = int'(out_data);
        err  = int'(out_err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("watchdog expired: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, data, err, a, held;

        k_h = 1.0;
        for (int i = 1; i <= 14; i++) begin
            k_h = k_h * $sqrt(1.0 - 1.0 / real'(1 << (2 * i)));
            if (i == 4 || i == 13) k_h = k_h * $sqrt(1.0 - 1.0 / real'(1 << (2 * i)));
        end

        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        run_op("a1p0", 16'h4000, lat, data, err);
        chk("a1p0_lat", lat, LAT);
        chk("a1p0_err", err, 0);
        chk_tol("a1p0_data", data, E_1, TOL);
        $display("op a=0x4000 lat=%0d data=0x%04h err=%0d", lat, data, err);

        run_op("a0p25", 16'h1000, lat, data, err);
        chk("a0p25_err", err, 0);
        chk_tol("a0p25_data", data, E_Q, TOL);
        $display("op a=0x1000 lat=%0d data=0x%04h err=%0d", lat, data, err);

        run_op("a1_16", 16'h0400, lat, data, err);
        chk("a1_16_err", err, 0);
        chk_tol("a1_16_data", data, E_16, TOL);
        $display("op a=0x0400 lat=%0d data=0x%04h err=%0d", lat, data, err);

        run_op("zero", 16'h0000, lat, data, err);
        chk("zero_lat", lat, 0);
        chk("zero_err", err, 1);
        chk("zero_data", data, 0);
        run_op("neg", 16'h8000, lat, data, err);
        chk("neg_lat", lat, 0);
        chk("neg_err", err, 1);
        chk("neg_data", data, 0);
        run_op("big", 16'h7400, lat, data, err);
        chk("big_lat", lat, 0);
        chk("big_err", err, 1);
        chk("big_data", data, 0);
        run_op("below_min", 16'h00FF, lat, data, err);
        chk("below_min_err", err, 1);
        run_op("at_min", 16'h0100, lat, data, err);
        chk("at_min_err", err, 0);
        chk("at_min_lat", lat, LAT);
        run_op("at_max", 16'h7000, lat, data, err);
        chk("at_max_err", err, 0);
        run_op("above_max", 16'h7001, lat, data, err);
        chk("above_max_err", err, 1);
        $display("op range-boundary and error cases done");

        // Result held under backpressure while a second operand waits.
        in_data  = 16'h1000;
        in_valid = 1'b1;
        tick();
        in_data = 16'h4000;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("hold_lat", lat, LAT);
        held = int'(out_data);
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_data_stable", int'(out_data), held);
            chk_tol("hold_data", int'(out_data), E_Q, TOL);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_valid", int'(out_valid), 0);
        chk("hold_release_in_ready", int'(in_ready), 1);
        tick();
        chk("hold_second_not_taken", int'(busy), 0);
        $display("op hold test data=0x%04h", held);

        // Reset in the middle of the pass sequence.
        in_data  = 16'h4000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk("midrst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 16'h4000, lat, data, err);
        chk("post_rst_lat", lat, LAT);
        chk_tol("post_rst_data", data, E_1, TOL);
        $display("op after mid-run reset a=0x4000 data=0x%04h", data);

        for (int i = 0; i < 100; i++) begin
            a = int'($urandom_range(16'h6F00, 16'h0400));
            run_op($sformatf("rand%0d", i), a, lat, data, err);
            chk($sformatf("rand%0d_lat", i), lat, LAT);
            chk($sformatf("rand%0d_err", i), err, 0);
            chk_tol($sformatf("rand%0d_data", i), data, model(a), TOL);
            $display("op rand%0d a=0x%04h data=0x%04h model=0x%04h", i, a, data, model(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
